// File: rtl/sipo_deserializer_pkg.sv
// Shared types for the serial-in/parallel-out deserializer.
// Optional parity checking is enabled with `define PARITY_EN.
package sipo_pkg;

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input stream plus valid/ready word output bundle.
// Build option PARITY_EN only changes how parity_err is driven.
interface sipo_deserializer_if #(
   parameter int WIDTH = 4
);
   logic             sin;
   logic             sin_valid;
   logic             sof;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             overrun;
   logic             parity_err;

   modport master (
      output sin, sin_valid, sof, dout_ready,
      input  dout, dout_valid, overrun, parity_err
   );

   modport slave (
      input  sin, sin_valid, sof, dout_ready,
      output dout, dout_valid, overrun, parity_err
   );
endinterface

// File: rtl/sipo_deserializer_out_buf.sv
// One-word valid/ready holding register with overrun detection.
// Unaffected by the PARITY_EN build option.
module sipo_out_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_overrun
);
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_ovr;
   logic             w_can_load;

   // A word draining this edge frees the slot for back-to-back loads.
   assign w_can_load = !r_valid || i_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ovr <= i_load && !w_can_load;
         if (i_load && w_can_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_ovr;
endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer with sof framing.
// Define PARITY_EN to expect an even-parity bit after each word.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter bit CONTINUOUS = 1'b1
) (
   input logic               clk,
   input logic               reset,
   sipo_deserializer_if.slave bus
);
   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sr;
   state_t           w_done_state;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_word;
   logic             w_bit;
   logic             w_load;

   assign w_shift      = {r_sr[WIDTH-2:0], bus.sin};
   assign w_bit        = bus.sin_valid && !bus.sof;
   assign w_done_state = CONTINUOUS ? SHIFT : IDLE;

`ifdef PARITY_EN
   logic r_perr;

   // Parity bit closes the word; only a clean word reaches the buffer.
   assign w_word = r_sr;
   assign w_load = w_bit && (r_state == PARITY)
                   && ((^{r_sr, bus.sin}) == 1'b0);
   assign bus.parity_err = r_perr;
`else
   assign w_word = w_shift;
   assign w_load = w_bit && (r_state == SHIFT) && (r_cnt == LAST);
   assign bus.parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sr    <= '0;
`ifdef PARITY_EN
         r_perr  <= 1'b0;
`endif
      end else begin
`ifdef PARITY_EN
         r_perr <= 1'b0;
`endif
         // sof restarts framing in any state, dropping a partial word.
         if (bus.sin_valid && bus.sof) begin
            r_sr    <= {{(WIDTH-1){1'b0}}, bus.sin};
            r_cnt   <= CW'(1);
            r_state <= SHIFT;
         end else if (w_bit) begin
            unique case (r_state)
               IDLE: begin
               end
               SHIFT: begin
                  r_sr <= w_shift;
                  if (r_cnt == LAST) begin
`ifdef PARITY_EN
                     r_state <= PARITY;
                     r_cnt   <= CW'(WIDTH);
`else
                     r_state <= w_done_state;
                     r_cnt   <= '0;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
`ifdef PARITY_EN
               PARITY: begin
                  r_perr  <= ^{r_sr, bus.sin};
                  r_state <= w_done_state;
                  r_cnt   <= '0;
               end
`endif
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   sipo_out_buf #(
      .WIDTH (WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_data    (w_word),
      .i_ready   (bus.dout_ready),
      .o_data    (bus.dout),
      .o_valid   (bus.dout_valid),
      .o_overrun (bus.overrun)
   );
endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer (WIDTH=4, CONTINUOUS=1).
// Parity cases run only when PARITY_EN is defined.
module tb_sipo_deserializer;
   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   hs_cnt;
   int   ovr_cnt;
   logic [3:0] exp_q[$];

   sipo_deserializer_if #(.WIDTH(4)) bus();

   sipo_deserializer #(
      .WIDTH      (4),
      .CONTINUOUS (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted word is checked against the queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.overrun) ovr_cnt++;
         if (bus.dout_valid && bus.dout_ready) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_word: got %0h expected none",
                        bus.dout);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (bus.dout !== e) begin
                  failures++;
                  $display("FAIL word: got %0h expected %0h", bus.dout, e);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic b, input logic s);
      bus.sin       = b;
      bus.sof       = s;
      bus.sin_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.sin_valid = 1'b0;
      bus.sof       = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w, input logic s);
      for (int i = 3; i >= 0; i--) begin
         send(w[i], (i == 3) ? s : 1'b0);
      end
`ifdef PARITY_EN
      send(^w, 1'b0);
`endif
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      hs_cnt   = 0;
      ovr_cnt  = 0;
      reset          = 1'b1;
      bus.sin        = 1'b0;
      bus.sin_valid  = 1'b0;
      bus.sof        = 1'b0;
      bus.dout_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dout", bus.dout, 4'h0);
      chk("rst_valid", bus.dout_valid, 1'b0);
      chk("rst_ovr", bus.overrun, 1'b0);
      chk("rst_perr", bus.parity_err, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(1);
      chk("post_rst_valid", bus.dout_valid, 1'b0);

      // Single word, latency one clock
      bus.dout_ready = 1'b1;
      exp_q.push_back(4'b1001);
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
`ifdef PARITY_EN
      send(1'b0, 1'b0);
`endif
      chk("t2_valid", bus.dout_valid, 1'b1);
      chk("t2_dout", bus.dout, 4'b1001);
      idle(1);
      chk("t2_clear", bus.dout_valid, 1'b0);

      // Continuous stream, no sof between words
      exp_q.push_back(4'b1010);
      exp_q.push_back(4'b1011);
      exp_q.push_back(4'b1110);
      send_word(4'b1010, 1'b1);
      chk("t3_w1", bus.dout, 4'b1010);
      send_word(4'b1011, 1'b0);
      chk("t3_w2", bus.dout, 4'b1011);
      send_word(4'b1110, 1'b0);
      chk("t3_w3", bus.dout, 4'b1110);
      idle(2);
      chk("t3_hs", hs_cnt, 4);

      // Backpressure and overrun
      bus.dout_ready = 1'b0;
      exp_q.push_back(4'b1001);
      send_word(4'b1001, 1'b1);
      chk("t4_valid", bus.dout_valid, 1'b1);
      send_word(4'b0110, 1'b1);
      chk("t4_ovr", bus.overrun, 1'b1);
      chk("t4_keep", bus.dout, 4'b1001);
      idle(1);
      chk("t4_ovr_pulse", bus.overrun, 1'b0);
      chk("t4_hold", bus.dout, 4'b1001);
      bus.dout_ready = 1'b1;
      idle(1);
      chk("t4_drain", bus.dout_valid, 1'b0);

      // sof mid-word discards the partial word
      exp_q.push_back(4'b0000);
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      send_word(4'b0000, 1'b1);
      chk("t5_valid", bus.dout_valid, 1'b1);
      chk("t5_dout", bus.dout, 4'b0000);
      idle(1);

      // Reset in mid-word, stray bits then ignored until sof
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      chk("rst_mid_valid", bus.dout_valid, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      idle(1);
      chk("idle_ignore", bus.dout_valid, 1'b0);
      exp_q.push_back(4'b0110);
      send_word(4'b0110, 1'b1);
      chk("clean_dout", bus.dout, 4'b0110);
      idle(1);

`ifdef PARITY_EN
      exp_q.push_back(4'b1110);
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      chk("t6_valid", bus.dout_valid, 1'b1);
      chk("t6_dout", bus.dout, 4'b1110);
      idle(1);
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk("t6_perr", bus.parity_err, 1'b1);
      chk("t6_drop", bus.dout_valid, 1'b0);
      idle(1);
      chk("t6_perr_pulse", bus.parity_err, 1'b0);
`endif

      idle(3);
      chk("q_empty", exp_q.size(), 0);
      chk("ovr_total", ovr_cnt, 1);
`ifdef PARITY_EN
      chk("hs_total", hs_cnt, 8);
`else
      chk("hs_total", hs_cnt, 7);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
